// File: rtl/syn_current.sv
// syn_current: synaptic input stage for a leaky integrate-and-fire neuron.
// Each cycle it forms the weighted sum of the presynaptic spikes and adds it
// into a leaky 8-bit current register that saturates at 255. Weights are
// loaded through a valid/ready write port. A clear sequencer zeroes the
// weight bank one entry per cycle.
module syn_current #(
    parameter int N_SYN       = 8,
    parameter int W_WIDTH     = 4,
    parameter int DECAY_SHIFT = 2,
    parameter int W_RST       = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SYN-1:0]         spike_in,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(N_SYN)-1:0] wr_addr,
    input  logic [W_WIDTH-1:0]       wr_data,
    input  logic                     clr_w,
    output logic                     busy,
    output logic [7:0]               current,
    output logic                     sat
);

    localparam int AW    = $clog2(N_SYN);
    // Wide enough for N_SYN full-scale weights plus a full 8-bit current.
    localparam int SUM_W = W_WIDTH + AW + 1;
    localparam int NXT_W = 8 + AW + W_WIDTH + 1;

    localparam logic [AW-1:0]      LAST_IDX = AW'(N_SYN - 1);
    localparam logic [W_WIDTH-1:0] W_RST_V  = W_WIDTH'(W_RST);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e               state_q;
    logic [AW-1:0]        clr_idx_q;
    logic [W_WIDTH-1:0]   weight_q [N_SYN];
    logic [7:0]           current_q, current_d;
    logic                 sat_q, sat_d;
    logic [SUM_W-1:0]     sum_d;
    logic [7:0]           leak_d;
    logic [NXT_W-1:0]     nxt_d;
    logic                 wr_fire;

    // A clear request takes priority over a write in the same cycle, so the
    // port stops accepting as soon as clr_w rises and until the clear ends.
    assign wr_ready = (state_q == IDLE) && !clr_w && !rst;
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = (state_q == CLEAR);
    assign current  = current_q;
    assign sat      = sat_q;

    // Clear sequencer: walk the clear index once over the weight bank.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_w) begin
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end
                    clr_idx_q <= clr_idx_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Weight bank: clear sequencer first, then accepted writes; an address
    // beyond the bank matches no entry and is silently dropped.
    // NOTE: the bank is a small flop array with a defined reset value, so it
    // is reset explicitly rather than left to power-up contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SYN; i++) begin
            if (rst) begin
                weight_q[i] <= W_RST_V;
            end else if (state_q == CLEAR && clr_idx_q == AW'(i)) begin
                weight_q[i] <= '0;
            end else if (wr_fire && wr_addr == AW'(i)) begin
                weight_q[i] <= wr_data;
            end
        end
    end

    // Next current: leak with a floor of 1 so it always reaches zero, add the
    // weighted spike sum, then clip to 8 bits.
    // NOTE: every variable gets its default at the top of the block so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (spike_in[i]) begin
                sum_d = sum_d + SUM_W'(weight_q[i]);
            end
        end
        leak_d = current_q >> DECAY_SHIFT;
        if (current_q != 8'd0 && leak_d == 8'd0) begin
            leak_d = 8'd1;
        end
        nxt_d     = NXT_W'(current_q) - NXT_W'(leak_d) + NXT_W'(sum_d);
        sat_d     = (nxt_d > NXT_W'(255));
        current_d = sat_d ? 8'hFF : nxt_d[7:0];
    end

    // Current and saturation flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            current_q <= 8'd0;
            sat_q     <= 1'b0;
        end else begin
            current_q <= current_d;
            sat_q     <= sat_d;
        end
    end

endmodule

// File: tb/tb_syn_current.sv
// Self-checking bench for syn_current: directed tables for the leak and
// saturation sequences, hand-written corner cases for write collisions,
// clearing and reset, then random traffic against a behavioural model.
module tb_syn_current;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] spike_in;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       clr_w;
    logic       busy;
    logic [7:0] current;
    logic       sat;

    // Second instance with a non-power-of-two bank so out-of-range addresses exist.
    logic [5:0] s6_spike;
    logic       w6_valid;
    logic       w6_ready;
    logic [2:0] w6_addr;
    logic [3:0] w6_data;
    logic       c6_clr;
    logic       b6_busy;
    logic [7:0] c6_current;
    logic       s6_sat;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] spike;
        int         cur;
        logic       sat;
    } vec_t;

    always #5 clk = ~clk;

    syn_current u_dut (
        .clk      (clk),
        .rst      (rst),
        .spike_in (spike_in),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_w    (clr_w),
        .busy     (busy),
        .current  (current),
        .sat      (sat)
    );

    syn_current #(.N_SYN(6)) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .spike_in (s6_spike),
        .wr_valid (w6_valid),
        .wr_ready (w6_ready),
        .wr_addr  (w6_addr),
        .wr_data  (w6_data),
        .clr_w    (c6_clr),
        .busy     (b6_busy),
        .current  (c6_current),
        .sat      (s6_sat)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        wr_valid = 1'b1;
        wr_addr  = 3'(a);
        wr_data  = 4'(d);
        #1;
        check($sformatf("wr_ready@wr%0d", a), int'(wr_ready), 1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        spike_in = 8'h00;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t leak_tbl [11];
        vec_t sat_tbl  [6];
        int   mw [8];
        int   mcur;
        int   clr_left;
        int   sum, leak, nxt;
        int   exp_sat;

        leak_tbl = '{'{8'h09, 15, 1'b0}, '{8'h00, 12, 1'b0}, '{8'h00, 9, 1'b0},
                     '{8'h00, 7, 1'b0},  '{8'h00, 6, 1'b0},  '{8'h00, 5, 1'b0},
                     '{8'h00, 4, 1'b0},  '{8'h00, 3, 1'b0},  '{8'h00, 2, 1'b0},
                     '{8'h00, 1, 1'b0},  '{8'h00, 0, 1'b0}};
        sat_tbl  = '{'{8'hFF, 120, 1'b0}, '{8'hFF, 210, 1'b0}, '{8'hFF, 255, 1'b1},
                     '{8'hFF, 255, 1'b1}, '{8'h00, 192, 1'b0}, '{8'h00, 144, 1'b0}};

        rst = 1'b1; spike_in = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_w = 1'b0;
        s6_spike = '0; w6_valid = 1'b0; w6_addr = '0; w6_data = '0; c6_clr = 1'b0;

        // Reset and defaults.
        step();
        check("wr_ready_in_rst", int'(wr_ready), 0);
        step();
        rst = 1'b0;
        step();
        check("rst_current", int'(current), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_wr_ready", int'(wr_ready), 1);

        spike_in = 8'h01;
        step();
        check("single_spike_cur", int'(current), 1);
        check("single_spike_sat", int'(sat), 0);
        spike_in = 8'h00;
        step();
        check("floor_decay_cur", int'(current), 0);

        // Out-of-range write on the 6-synapse instance: handshake, no change.
        w6_valid = 1'b1; w6_addr = 3'd7; w6_data = 4'd15;
        #1;
        check("oor_wr_ready", int'(w6_ready), 1);
        step();
        w6_valid = 1'b0;
        s6_spike = 6'h3F;
        step();
        check("oor_no_change_cur", int'(c6_current), 6);
        s6_spike = 6'h00;

        // Weighted sum and leak.
        wr(0, 10);
        wr(3, 5);
        for (int i = 0; i < 11; i++) begin
            spike_in = leak_tbl[i].spike;
            step();
            check($sformatf("leak_cur[%0d]", i), int'(current), leak_tbl[i].cur);
            check($sformatf("leak_sat[%0d]", i), int'(sat), int'(leak_tbl[i].sat));
        end

        // Saturation.
        for (int i = 0; i < 8; i++) wr(i, 15);
        for (int i = 0; i < 6; i++) begin
            spike_in = sat_tbl[i].spike;
            step();
            check($sformatf("sat_cur[%0d]", i), int'(current), sat_tbl[i].cur);
            check($sformatf("sat_flag[%0d]", i), int'(sat), int'(sat_tbl[i].sat));
        end
        idle_cycles(40);
        check("sat_decay_to_zero", int'(current), 0);

        // Write/spike collision: old weight used on the colliding edge.
        wr(2, 3);
        wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'd9; spike_in = 8'h04;
        step();
        wr_valid = 1'b0;
        check("collide_old_weight", int'(current), 3);
        step();
        check("collide_new_weight", int'(current), 11);

        // Clear sequence with a simultaneous write and a repeated clr_w.
        for (int i = 0; i < 8; i++) wr(i, 7);
        idle_cycles(20);
        check("pre_clear_cur", int'(current), 0);
        clr_w = 1'b1; wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'd15;
        #1;
        check("clr_blocks_ready", int'(wr_ready), 0);
        step();
        clr_w = 1'b0; wr_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            clr_w = (k == 3);
            #1;
            check($sformatf("clr_busy[%0d]", k), int'(busy), 1);
            check($sformatf("clr_ready[%0d]", k), int'(wr_ready), 0);
            step();
        end
        clr_w = 1'b0;
        check("clr_done_busy", int'(busy), 0);
        check("clr_done_ready", int'(wr_ready), 1);
        spike_in = 8'hFF;
        step();
        check("cleared_sum", int'(current), 0);
        spike_in = 8'h00;

        // Reset in the middle of a clear.
        clr_w = 1'b1;
        step();
        clr_w = 1'b0;
        step(); step(); step();
        check("midclr_busy_before", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midclr_busy_after", int'(busy), 0);
        check("midclr_ready_after", int'(wr_ready), 1);
        spike_in = 8'hFF;
        step();
        check("midclr_weights_rst", int'(current), 8);

        // Random traffic against the model.
        rst = 1'b1; spike_in = 8'h00;
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 8; i++) mw[i] = 1;
        mcur = 0;
        clr_left = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            spike_in = 8'($urandom);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr  = 3'($urandom);
            wr_data  = 4'($urandom);
            clr_w    = ($urandom_range(0, 39) == 0);
            #1;
            check("rnd_wr_ready", int'(wr_ready), int'(clr_left == 0 && !clr_w));
            check("rnd_busy", int'(busy), int'(clr_left != 0));

            sum = 0;
            for (int i = 0; i < 8; i++) if (spike_in[i]) sum += mw[i];
            leak = mcur / 4;
            if (mcur != 0 && leak == 0) leak = 1;
            nxt = mcur - leak + sum;
            exp_sat = (nxt > 255) ? 1 : 0;
            mcur = (nxt > 255) ? 255 : nxt;
            if (clr_left != 0) begin
                mw[8 - clr_left] = 0;
                clr_left--;
            end else if (clr_w) begin
                clr_left = 8;
            end else if (wr_valid) begin
                mw[wr_addr] = int'(wr_data);
            end

            step();
            check("rnd_current", int'(current), mcur);
            check("rnd_sat", int'(sat), exp_sat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_current.md
# syn_current

Synaptic input stage that drives the 8-bit `current` input of the leaky integrate-and-fire neuron. It samples a vector of presynaptic spike lines every cycle and forms a weighted sum from a bank of programmable per-synapse weights. It adds that sum into a leaky synaptic-current register and presents the saturated 8-bit result to the neuron. A valid/ready write port loads weights; a sequenced clear state machine zeroes the weight bank.

## Interface
- `N_SYN`, 8, number of presynaptic inputs (2..16)
- `W_WIDTH`, 4, unsigned weight width in bits (1..6)
- `DECAY_SHIFT`, 2, leak shift applied to the current register each cycle (0..7)
- `W_RST`, 1, reset value of every weight
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `spike_in`  in  N_SYN  presynaptic spikes, bit i = synapse i, sampled every cycle
- `wr_valid`  in  1  weight write request
- `wr_ready`  out  1  write port can accept
- `wr_addr`  in  clog2(N_SYN)  synapse index to write
- `wr_data`  in  W_WIDTH  new weight
- `clr_w`  in  1  one-cycle pulse: start zeroing all weights
- `busy`  out  1  clear sequence in progress
- `current`  out  8  synaptic current to neuron, registered
- `sat`  out  1  registered; current clipped at 255 this update

## Operation
- FSM states: IDLE, CLEAR. Reset → IDLE.
- IDLE: `wr_ready`=1. A write occurs when `wr_valid && wr_ready`: `weight[wr_addr]` ← `wr_data` at that edge. If `wr_addr` ≥ N_SYN, the handshake completes and no weight changes.
- IDLE + `clr_w`=1 → CLEAR with clear index 0. `clr_w` wins over a simultaneous write, and that write is not accepted: `wr_ready` is combinationally 0 whenever `clr_w`=1 or state=CLEAR.
- CLEAR: one weight per cycle is zeroed, index 0..N_SYN-1. After index N_SYN-1 is zeroed, the FSM returns to IDLE. `busy`=1 for exactly N_SYN cycles. `clr_w` during CLEAR is ignored.
- Integration runs every cycle in both states:
  - sum = Σ over i of `spike_in[i]` ? weight[i] : 0. Use the weights currently held; a write on the same edge affects only the next cycle.
  - leak = `current` >> DECAY_SHIFT. If `current` ≠ 0 and leak = 0, then leak = 1, so the current always decays to 0.
  - nxt = `current` − leak + sum, computed at ≥ 8 + clog2(N_SYN) + W_WIDTH bits, unsigned. No underflow is possible, since leak ≤ `current`.
  - `current` ← min(nxt, 255). `sat` ← (nxt > 255).
- With DECAY_SHIFT=0, leak = `current`, so `current` = sum of the previous cycle (no memory).
- Reset mid-CLEAR aborts the sequence. All weights return to W_RST. FSM → IDLE.

## Timing
- Reset values: `current`=0, `sat`=0, `busy`=0, `wr_ready`=1 the cycle after reset releases, all weights = W_RST, FSM=IDLE. `wr_ready`=0 while `rst`=1.
- Latency: `spike_in` at edge t affects `current` from edge t (visible in cycle t+1). Effect on neuron state is one further cycle.
- Write accepted at edge t: the new weight is used by spikes sampled at edge t+1 onward.
- `clr_w` at edge t: `busy`=1 from cycle t+1 through t+N_SYN. Weight k is zero from edge t+1+k. `wr_ready`=1 again in cycle t+N_SYN+1.
- Spikes during CLEAR use each weight's value at that edge, whether already cleared or not.
- `sat` is one pulse per clipped update, aligned with the clipped `current` value.

## Test plan
- Reset/defaults: assert `rst` 2 cycles, then `spike_in`=8'h01 for one cycle, then 0 → `current`=1 one cycle after the spike, then 0 on the next cycle (floor-decay rule); `sat`=0 throughout.
- Weighted sum and leak: write w0=10, w3=5 (DECAY_SHIFT=2); pulse `spike_in`=8'h09 once → `current` sequence 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0.
- Saturation: all weights=15, `spike_in`=8'hFF held → `current` 120, 210, 255 and holds 255 with `sat`=1 from the third update onward; drop spikes → `sat`=0 next update, `current` decays from 255 (192, 144, …).
- Write/spike collision: w2=3 held; write w2=9 at the same edge `spike_in`=8'h04 is sampled → that update adds 3; next spike adds 9; out-of-range `wr_addr` handshakes with no weight change.
- Clear sequence: all weights 7, pulse `clr_w` with a simultaneous `wr_valid` → write not accepted, `busy` high exactly 8 cycles, `wr_ready` low for those 8, then `spike_in`=8'hFF adds 0.
- Reset mid-clear: assert `rst` at clear index 3 → `busy`=0, FSM IDLE, all weights = W_RST (spike 8'hFF adds 8 with W_RST=1).
